// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and constants for the truth-table sequencer.
// Holds the FSM state enum, the vector-count helper and the settle-counter width.
package tt_seq_pkg;

  // Settle counter width; covers the largest legal settle time of 15 cycles.
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SETTLE_MAX = 15;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_e;

  function automatic int unsigned n_vec(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Stimulus/result bundle between the sequencer and its user.
// The master side requests sweeps and supplies f; the slave side is the sequencer.
interface truth_table_sequencer_if
  import tt_seq_pkg::*;
#(
  parameter int unsigned N_IN = 4
);
  localparam int unsigned N_VEC = n_vec(N_IN);

  logic             start;
  logic [N_VEC-1:0] exp_tt;
  logic             f_in;
  logic [N_IN-1:0]  x;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_VEC-1:0] tt;
  logic [N_IN:0]    err_count;
  logic [N_IN-1:0]  first_err_idx;

  modport master (
    output start, exp_tt, f_in,
    input  x, busy, done, pass, tt, err_count, first_err_idx
  );

  modport slave (
    input  start, exp_tt, f_in,
    output x, busy, done, pass, tt, err_count, first_err_idx
  );

endinterface

// File: rtl/truth_table_sequencer_settle_timer.sv
// Loadable up counter with a terminal-count flag.
// Counts while enabled; load takes priority and restarts from load_val.
module settle_timer
  import tt_seq_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == limit);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector of a combinational function, captures its truth table
// and compares it against a latched expected table.
module truth_table_sequencer
  import tt_seq_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  truth_table_sequencer_if.slave bus
);

  localparam int unsigned        N_VEC      = n_vec(N_IN);
  localparam logic [N_IN-1:0]    LAST_VEC   = {N_IN{1'b1}};
  localparam logic [CNT_W-1:0]   SETTLE_TC  = CNT_W'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [N_IN-1:0]  x_q;
  logic [N_VEC-1:0] tt_q;
  logic [N_VEC-1:0] exp_q;
  logic [N_IN:0]    err_q;
  logic [N_IN-1:0]  first_q;

  logic accept;
  logic in_drive;
  logic sampling;
  logic last_vec;
  logic mismatch;
  logic settle_tc;
  logic timer_load;

  // A start is only honoured when no sweep is running.
  assign accept     = ((state_q == StIdle) || (state_q == StDone)) && bus.start;
  assign in_drive   = (state_q == StDrive);
  assign sampling   = (state_q == StSample);
  assign last_vec   = (x_q == LAST_VEC);
  assign mismatch   = (bus.f_in != exp_q[x_q]);
  assign timer_load = accept || (in_drive && settle_tc);

  settle_timer #(
    .W (CNT_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val ('0),
    .en       (in_drive),
    .limit    (SETTLE_TC),
    .tc       (settle_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (settle_tc) begin
          state_d = StSample;
        end
      end
      StSample: begin
        state_d = last_vec ? StDone : StDrive;
      end
      default: state_d = StIdle;
    endcase
  end

  // Vector counter, capture register and mismatch bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      tt_q    <= '0;
      exp_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
    end else if (accept) begin
      x_q     <= '0;
      tt_q    <= '0;
      exp_q   <= bus.exp_tt;
      err_q   <= '0;
      first_q <= '0;
    end else if (sampling) begin
      tt_q[x_q] <= bus.f_in;
      if (mismatch) begin
        err_q <= err_q + 1'b1;
        if (err_q == '0) begin
          first_q <= x_q;
        end
      end
      // The final vector stays on x; there is no wrap back to 0.
      if (!last_vec) begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    bus.pass = 1'b0;
    unique case (state_q)
      StDrive, StSample: bus.busy = 1'b1;
      StDone: begin
        bus.done = 1'b1;
        bus.pass = (err_q == '0);
      end
      default: ;
    endcase
  end

  assign bus.x             = x_q;
  assign bus.tt            = tt_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_q;

endmodule
